cmp_hit_tracker: RTL and testbench

Sequential result tracker placed directly downstream of the 3-bit equal/diff comparator. Each valid cycle it consumes one comparator result bit (`r`) and the mode bit (`key`) that produced it. It keeps saturating statistics: total compares, hits, current consecutive-hit run and longest run. It emits a one-cycle pulse when the current run reaches a programmable threshold, so the comparator's per-word answers become sequence-level events for the next stage.

---
 rtl/cmp_pkg.sv | 13 +
 rtl/cmp_hit_tracker_sat_inc.sv | 21 ++
 rtl/cmp_hit_tracker.sv | 101 ++++++++++
 tb/tb_cmp_hit_tracker.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared comparator types: run-tracking state and comparator mode encodings.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        RUN  = 2'd2
    } run_state_e;

    localparam logic KEY_EQ   = 1'b0;
    localparam logic KEY_DIFF = 1'b1;

endpackage

// File: rtl/cmp_hit_tracker_sat_inc.sv
// Combinational saturating incrementer; at_max_c flags an all-ones result.
module sat_inc #(
    parameter int unsigned W = 8
) (
    input  logic         en,
    input  logic [W-1:0] val,
    output logic [W-1:0] sum_c,
    output logic         at_max_c
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    always_comb begin
        sum_c = val;
        if (en && (val != MAX)) begin
            sum_c = val + W'(1);
        end
        at_max_c = (sum_c == MAX);
    end

endmodule

// File: rtl/cmp_hit_tracker.sv
// Turns per-sample comparator results into saturating hit/run statistics
// and a one-cycle pulse when the current hit run reaches THRESH.
module cmp_hit_tracker
    import cmp_pkg::*;
#(
    parameter int unsigned CW     = 8,
    parameter int unsigned THRESH = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    input  logic          in_r,
    input  logic          in_key,
    output logic [CW-1:0] total_cnt,
    output logic [CW-1:0] hit_cnt,
    output logic [CW-1:0] run_len,
    output logic [CW-1:0] max_run,
    output logic          run_pulse,
    output logic          sat
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] THR     = CW'(THRESH);

    run_state_e    state_q;
    run_state_e    state_d;
    logic          last_key_q;
    logic          have_key;
    logic          mode_change;
    logic [CW-1:0] run_base;
    logic [CW-1:0] total_inc;
    logic [CW-1:0] hit_inc;
    logic [CW-1:0] run_inc;
    logic          total_max;
    logic          hit_max;
    logic          run_max;
    logic [CW-1:0] run_nxt;
    logic [CW-1:0] max_nxt;
    logic          pulse_nxt;
    logic          sat_nxt;

    assign have_key    = (state_q != IDLE);
    assign mode_change = have_key && (in_key != last_key_q);
    assign run_base    = mode_change ? '0 : run_len;

    sat_inc #(.W(CW)) u_total (
        .en       (1'b1),
        .val      (total_cnt),
        .sum_c    (total_inc),
        .at_max_c (total_max)
    );

    sat_inc #(.W(CW)) u_hit (
        .en       (in_r),
        .val      (hit_cnt),
        .sum_c    (hit_inc),
        .at_max_c (hit_max)
    );

    sat_inc #(.W(CW)) u_run (
        .en       (1'b1),
        .val      (run_base),
        .sum_c    (run_inc),
        .at_max_c (run_max)
    );

    // Next values for an accepted sample; only committed when in_valid is high.
    always_comb begin
        run_nxt   = in_r ? run_inc : '0;
        max_nxt   = (run_nxt > max_run) ? run_nxt : max_run;
        pulse_nxt = (run_nxt == THR) && (run_len != THR);
        sat_nxt   = sat || total_max || hit_max || (in_r && run_max) || (max_nxt == CNT_MAX);
        state_d   = in_r ? RUN : MISS;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q    <= IDLE;
            last_key_q <= KEY_EQ;
            total_cnt  <= '0;
            hit_cnt    <= '0;
            run_len    <= '0;
            max_run    <= '0;
            run_pulse  <= 1'b0;
            sat        <= 1'b0;
        end else if (in_valid) begin
            state_q    <= state_d;
            last_key_q <= in_key;
            total_cnt  <= total_inc;
            hit_cnt    <= hit_inc;
            run_len    <= run_nxt;
            max_run    <= max_nxt;
            run_pulse  <= pulse_nxt;
            sat        <= sat_nxt;
        end else begin
            run_pulse  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmp_hit_tracker.sv
// Scoreboard bench for cmp_hit_tracker: an 8-bit instance and a 2-bit
// instance whose threshold equals its saturation value.
module tb_cmp_hit_tracker;

    typedef struct {
        int t;
        int h;
        int rl;
        int mr;
        bit p;
        bit s;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, clr8, v8, r8, k8;
    logic [7:0] total8, hit8, run8, max8;
    logic       pulse8, sat8;

    logic       rst2, clr2, v2, r2, k2;
    logic [1:0] total2, hit2, run2, max2;
    logic       pulse2, sat2;

    int checks = 0;
    int errors = 0;

    exp_t q8[$];
    exp_t q2[$];

    cmp_hit_tracker #(.CW(8), .THRESH(3)) dut8 (
        .clk(clk), .rst(rst8), .clr(clr8), .in_valid(v8), .in_r(r8), .in_key(k8),
        .total_cnt(total8), .hit_cnt(hit8), .run_len(run8), .max_run(max8),
        .run_pulse(pulse8), .sat(sat8)
    );

    cmp_hit_tracker #(.CW(2), .THRESH(3)) dut2 (
        .clk(clk), .rst(rst2), .clr(clr2), .in_valid(v2), .in_r(r2), .in_key(k2),
        .total_cnt(total2), .hit_cnt(hit2), .run_len(run2), .max_run(max2),
        .run_pulse(pulse2), .sat(sat2)
    );

    function automatic void cmp_field(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endfunction

    function automatic void cmp_all(string tag, exp_t e, int t, int h, int rl, int mr,
                                    logic p, logic s);
        cmp_field({tag, ".total_cnt"}, t, e.t);
        cmp_field({tag, ".hit_cnt"}, h, e.h);
        cmp_field({tag, ".run_len"}, rl, e.rl);
        cmp_field({tag, ".max_run"}, mr, e.mr);
        cmp_field({tag, ".run_pulse"}, (p === 1'b1) ? 1 : 0, int'(e.p));
        cmp_field({tag, ".sat"}, (s === 1'b1) ? 1 : 0, int'(e.s));
    endfunction

    // Monitor: one expected entry per clock edge that followed a driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q8.size() > 0) begin
                e = q8.pop_front();
                cmp_all("cw8", e, int'(total8), int'(hit8), int'(run8), int'(max8), pulse8, sat8);
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                cmp_all("cw2", e, int'(total2), int'(hit2), int'(run2), int'(max2), pulse2, sat2);
            end
        end
    end

    // Drive one cycle on the selected instance and queue its expected result.
    task automatic step(input bit sel2, input logic rs, input logic cl, input logic v,
                        input logic r, input logic k, input int t, input int h,
                        input int rl, input int mr, input bit p, input bit s);
        exp_t e;
        @(negedge clk);
        rst8 = 1'b0; clr8 = 1'b0; v8 = 1'b0; r8 = 1'b0; k8 = 1'b0;
        rst2 = 1'b0; clr2 = 1'b0; v2 = 1'b0; r2 = 1'b0; k2 = 1'b0;
        e = '{t: t, h: h, rl: rl, mr: mr, p: p, s: s};
        if (sel2) begin
            rst2 = rs; clr2 = cl; v2 = v; r2 = r; k2 = k;
            q2.push_back(e);
        end else begin
            rst8 = rs; clr8 = cl; v8 = v; r8 = r; k8 = k;
            q8.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        rst8 = 1'b0; clr8 = 1'b0; v8 = 1'b0; r8 = 1'b0; k8 = 1'b0;
        rst2 = 1'b0; clr2 = 1'b0; v2 = 1'b0; r2 = 1'b0; k2 = 1'b0;

        //      sel rst clr v  r  k   tot hit run max pls sat
        step(0, 1,  0,  0, 0, 0,   0,  0,  0,  0,  0,  0);
        // Four equal-mode hits: pulse only when run reaches 3.
        step(0, 0,  0,  1, 1, 0,   1,  1,  1,  1,  0,  0);
        step(0, 0,  0,  1, 1, 0,   2,  2,  2,  2,  0,  0);
        step(0, 0,  0,  1, 1, 0,   3,  3,  3,  3,  1,  0);
        step(0, 0,  0,  1, 1, 0,   4,  4,  4,  4,  0,  0);
        // hit, hit, miss, hit.
        step(0, 0,  1,  0, 0, 0,   0,  0,  0,  0,  0,  0);
        step(0, 0,  0,  1, 1, 0,   1,  1,  1,  1,  0,  0);
        step(0, 0,  0,  1, 1, 0,   2,  2,  2,  2,  0,  0);
        step(0, 0,  0,  1, 0, 0,   3,  2,  0,  2,  0,  0);
        step(0, 0,  0,  1, 1, 0,   4,  3,  1,  2,  0,  0);
        // Mode change mid-run restarts the run at 1.
        step(0, 0,  1,  0, 0, 0,   0,  0,  0,  0,  0,  0);
        step(0, 0,  0,  1, 1, 0,   1,  1,  1,  1,  0,  0);
        step(0, 0,  0,  1, 1, 0,   2,  2,  2,  2,  0,  0);
        step(0, 0,  0,  1, 1, 1,   3,  3,  1,  2,  0,  0);
        step(0, 0,  0,  1, 1, 1,   4,  4,  2,  2,  0,  0);
        // Mode change on a miss.
        step(0, 0,  0,  1, 0, 0,   5,  4,  0,  2,  0,  0);
        // clr with a valid hit mid-run drops the sample.
        step(0, 0,  1,  0, 0, 0,   0,  0,  0,  0,  0,  0);
        step(0, 0,  0,  1, 1, 0,   1,  1,  1,  1,  0,  0);
        step(0, 0,  0,  1, 1, 0,   2,  2,  2,  2,  0,  0);
        step(0, 0,  1,  1, 1, 0,   0,  0,  0,  0,  0,  0);
        step(0, 0,  0,  1, 1, 1,   1,  1,  1,  1,  0,  0);
        // Idle gaps between hits hold state and keep the pulse low.
        step(0, 0,  1,  0, 0, 0,   0,  0,  0,  0,  0,  0);
        step(0, 0,  0,  1, 1, 0,   1,  1,  1,  1,  0,  0);
        step(0, 0,  0,  0, 1, 1,   1,  1,  1,  1,  0,  0);
        step(0, 0,  0,  1, 1, 0,   2,  2,  2,  2,  0,  0);
        step(0, 0,  0,  0, 0, 0,   2,  2,  2,  2,  0,  0);
        step(0, 0,  0,  1, 1, 0,   3,  3,  3,  3,  1,  0);
        step(0, 0,  0,  0, 1, 0,   3,  3,  3,  3,  0,  0);
        step(0, 0,  0,  1, 1, 0,   4,  4,  4,  4,  0,  0);
        // rst wins over clr and a valid sample.
        step(0, 1,  1,  1, 1, 0,   0,  0,  0,  0,  0,  0);

        // 2-bit instance: saturation at 3, threshold equal to saturation.
        step(1, 1,  0,  0, 0, 0,   0,  0,  0,  0,  0,  0);
        step(1, 0,  0,  1, 1, 0,   1,  1,  1,  1,  0,  0);
        step(1, 0,  0,  1, 1, 0,   2,  2,  2,  2,  0,  0);
        step(1, 0,  0,  1, 1, 0,   3,  3,  3,  3,  1,  1);
        step(1, 0,  0,  1, 1, 0,   3,  3,  3,  3,  0,  1);
        step(1, 0,  0,  1, 1, 0,   3,  3,  3,  3,  0,  1);
        step(1, 0,  0,  0, 0, 0,   3,  3,  3,  3,  0,  1);
        step(1, 0,  0,  1, 0, 0,   3,  3,  0,  3,  0,  1);
        step(1, 0,  1,  0, 0, 0,   0,  0,  0,  0,  0,  0);

        @(negedge clk);
        rst8 = 1'b0; clr8 = 1'b0; v8 = 1'b0;
        rst2 = 1'b0; clr2 = 1'b0; v2 = 1'b0;

        budget = 20;
        while ((q8.size() > 0 || q2.size() > 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (q8.size() > 0 || q2.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q8.size() + q2.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
